// File: rtl/demux_16_route.sv
`default_nettype none
// ============================================================================
// demux_16_route : valid/ready 1->2 sample router with per-channel FWFT FIFOs
//                  and optional A/B ping-pong interleave.
// Revision 1.0 - initial release
// ============================================================================
module demux_16_route #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  input  logic             alt,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CW-1:0]    a_count,
  output logic [CW-1:0]    b_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Channel index 0 is A, 1 is B throughout.
  logic                  toggle;
  logic                  tgt;
  logic                  accept;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            valid;
  logic [1:0]            full;
  logic [1:0][WIDTH-1:0] head;
  logic [1:0][CW-1:0]    cnt;

  assign tgt      = alt ? toggle : en;
  assign in_ready = !full[tgt];
  assign accept   = in_valid && in_ready;
  assign push     = {accept & tgt, accept & ~tgt};
  assign pop      = valid & {b_ready, a_ready};

  // Forcing toggle low outside ping-pong mode makes every alt run start on A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle <= 1'b0;
    end else if (!alt) begin
      toggle <= 1'b0;
    end else if (accept) begin
      toggle <= ~toggle;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    always_ff @(posedge clk) begin
      if (push[ch]) begin
        mem[wr_ptr] <= in_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[ch]) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop[ch]) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push[ch] && !pop[ch]) begin
          count <= count + 1'b1;
        end else if (pop[ch] && !push[ch]) begin
          count <= count - 1'b1;
        end
      end
    end

    assign valid[ch] = (count != '0);
    assign full[ch]  = (count == CW'(DEPTH));
    assign cnt[ch]   = count;
    assign head[ch]  = valid[ch] ? mem[rd_ptr] : '0;
  end

  assign a_data  = head[0];
  assign b_data  = head[1];
  assign a_valid = valid[0];
  assign b_valid = valid[1];
  assign a_count = cnt[0];
  assign b_count = cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_demux_16_route.sv
`default_nettype none
// tb_demux_16_route : directed scenarios plus randomized traffic, checked
// against a queue-based reference of the two channel buffers.
module tb_demux_16_route;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             en = 1'b0;
  logic             alt = 1'b0;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready = 1'b0;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready = 1'b0;
  logic [CW-1:0]    a_count;
  logic [CW-1:0]    b_count;

  int checks = 0;
  int errors = 0;

  // Reference: contents of each channel, oldest first, plus ping-pong phase.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic             phase_b = 1'b0;

  demux_16_route #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .en(en), .alt(alt),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    repeat (DEPTH + 2) step();
  endtask

  // Monitor: inputs are stable at the falling edge, so the coming rising edge's
  // pops and accepts are known here. Pops are settled before the push so that a
  // simultaneous push/pop compares against the old head.
  always @(negedge clk) begin
    logic go_b;
    logic room;
    logic take;
    if (rst_n) begin
      chk("a_count", 32'(a_count), 32'(qa.size()));
      chk("b_count", 32'(b_count), 32'(qb.size()));
      chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
      chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
      chk("a_data", 32'(a_data), (qa.size() != 0) ? 32'(qa[0]) : 32'd0);
      chk("b_data", 32'(b_data), (qb.size() != 0) ? 32'(qb[0]) : 32'd0);
      go_b = alt ? phase_b : en;
      room = go_b ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
      chk("in_ready", 32'(in_ready), 32'(room));
      take = in_valid && room;
      if (a_ready && qa.size() != 0) void'(qa.pop_front());
      if (b_ready && qb.size() != 0) void'(qb.pop_front());
      if (take) begin
        if (go_b) qb.push_back(in_data);
        else      qa.push_back(in_data);
      end
      if (!alt)      phase_b = 1'b0;
      else if (take) phase_b = !phase_b;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic hold;
    // 1: reset state, single word to A with consumer stalled
    #2;
    chk("rst a_count", 32'(a_count), 32'd0);
    chk("rst b_count", 32'(b_count), 32'd0);
    chk("rst a_valid", 32'(a_valid), 32'd0);
    chk("rst b_valid", 32'(b_valid), 32'd0);
    #10 rst_n = 1'b1;
    step();
    in_data = 16'h1234; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1 a_valid", 32'(a_valid), 32'd1);
    chk("t1 a_data", 32'(a_data), 32'h1234);
    chk("t1 a_count", 32'(a_count), 32'd1);
    chk("t1 b_valid", 32'(b_valid), 32'd0);

    // 2: ping-pong 1..6, each word visible one cycle later on its channel
    drain();
    alt = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_data = 16'(i); in_valid = 1'b1;
      step();
      if (i % 2 == 1) begin
        chk("t2 a_valid", 32'(a_valid), 32'd1);
        chk("t2 a_data", 32'(a_data), 32'(i));
      end else begin
        chk("t2 b_valid", 32'(b_valid), 32'd1);
        chk("t2 b_data", 32'(b_data), 32'(i));
      end
    end
    in_valid = 1'b0; alt = 1'b0;
    step();
    alt = 1'b1; a_ready = 1'b0; b_ready = 1'b0;
    in_data = 16'h0077; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t2 realt a_data", 32'(a_data), 32'h0077);
    chk("t2 realt b_valid", 32'(b_valid), 32'd0);

    // 3: fill B, A still flows, no pass-through on full
    drain();
    alt = 1'b0; en = 1'b1; b_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 16'h0030 + 16'(i); in_valid = 1'b1;
      step();
    end
    chk("t3 b_count full", 32'(b_count), 32'(DEPTH));
    chk("t3 in_ready full", 32'(in_ready), 32'd0);
    in_valid = 1'b0; en = 1'b0; in_data = 16'h003A;
    in_valid = 1'b1;
    #1 chk("t3 a_ready_path", 32'(in_ready), 32'd1);
    step();
    chk("t3 a_data", 32'(a_data), 32'h003A);
    en = 1'b1; in_data = 16'h0035;
    #1 chk("t3 fifth blocked", 32'(in_ready), 32'd0);
    step();
    chk("t3 b_count hold", 32'(b_count), 32'(DEPTH));
    b_ready = 1'b1;
    #1 chk("t3 full+pop ready", 32'(in_ready), 32'd0);
    step();
    chk("t3 b_count after pop", 32'(b_count), 32'(DEPTH - 1));
    step();
    in_valid = 1'b0;
    chk("t3 b_count push+pop", 32'(b_count), 32'(DEPTH - 1));

    // 4: simultaneous push and pop at count 2
    drain();
    en = 1'b0; a_ready = 1'b0;
    in_data = 16'h0041; in_valid = 1'b1; step();
    in_data = 16'h0042; step();
    chk("t4 a_count pre", 32'(a_count), 32'd2);
    in_data = 16'h0043; a_ready = 1'b1; step();
    in_valid = 1'b0;
    chk("t4 a_count", 32'(a_count), 32'd2);
    chk("t4 a_head", 32'(a_data), 32'h0042);

    // 5: asynchronous reset mid-burst
    drain();
    alt = 1'b1; a_ready = 1'b0; b_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'h0051 + 16'(i); in_valid = 1'b1;
      step();
    end
    #2 rst_n = 1'b0;
    qa.delete(); qb.delete(); phase_b = 1'b0;
    #1;
    chk("t5 a_count", 32'(a_count), 32'd0);
    chk("t5 b_count", 32'(b_count), 32'd0);
    chk("t5 a_valid", 32'(a_valid), 32'd0);
    chk("t5 b_valid", 32'(b_valid), 32'd0);
    chk("t5 a_data", 32'(a_data), 32'd0);
    chk("t5 b_data", 32'(b_data), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    in_data = 16'h005A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t5 first a_valid", 32'(a_valid), 32'd1);
    chk("t5 first a_data", 32'(a_data), 32'h005A);
    chk("t5 first b_valid", 32'(b_valid), 32'd0);

    // 6: randomized traffic; source holds a word until it is accepted
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      hold = in_valid && !in_ready;
      step();
      if (!hold) begin
        in_valid = ($urandom_range(9) < 7);
        in_data  = 16'($urandom);
        en       = 1'($urandom);
        if ($urandom_range(31) == 0) alt = !alt;
      end
      a_ready = ($urandom_range(9) < 6);
      b_ready = ($urandom_range(9) < 5);
    end
    drain();
    chk("end qa empty", 32'(qa.size()), 32'd0);
    chk("end qb empty", 32'(qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
